// File: rtl/handshake_const_sink.sv
// handshake_const_sink: batches accepted data tokens into control tokens; comparator enabled by HANDSHAKE_CONST_SINK_CHECK_EN
module handshake_const_sink #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] EXPECTED    = '0,
    parameter int                    TOKEN_COUNT = 4,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  mismatch,
    output logic [DATA_WIDTH-1:0] last_value
);
    typedef enum logic {ACCEPT, EMIT} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TOKEN_COUNT - 1);
    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] batch, batch_nxt;
    logic                 in_fire;
    assign ins_ready  = state == ACCEPT;
    assign ctrl_valid = state == EMIT;
    assign in_fire    = ins_valid && ins_ready;
    // state and batch counter registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= ACCEPT;
            batch <= '0;
        end else begin
            state <= state_nxt;
            batch <= batch_nxt;
        end
    // batch completion moves to EMIT; output fire returns to ACCEPT
    always_comb begin
        state_nxt = state;
        batch_nxt = batch;
        if (in_fire) begin
            batch_nxt = batch == LAST ? '0 : batch + 1'b1;
            state_nxt = batch == LAST ? EMIT : ACCEPT;
        end else if (ctrl_valid && ctrl_ready)
            state_nxt = ACCEPT;
    end
    // saturating total count and last accepted token
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            count      <= '0;
            last_value <= '0;
        end else if (in_fire) begin
            count      <= count == '1 ? count : count + 1'b1;
            last_value <= ins;
        end
`ifdef HANDSHAKE_CONST_SINK_CHECK_EN
    // sticky flag for any accepted token that differs from EXPECTED
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            mismatch <= 1'b0;
        else if (in_fire && ins != EXPECTED)
            mismatch <= 1'b1;
`else
    logic unused_expected;
    assign unused_expected = ^EXPECTED;
    assign mismatch        = 1'b0;
`endif
endmodule

// File: doc/handshake_const_sink.md
# handshake_const_sink

Receiving end of a constant-producing dataflow channel: consumes data tokens on a valid/ready input channel, checks each against a compile-time expected value, and returns one control token on an output channel after every TOKEN_COUNT accepted tokens. It sits downstream of constant generators in the dataflow netlist, closing the loop that constant sources open with their control-in / data-out handshake. It also provides a running token count and a sticky mismatch flag for on-chip self-check.

## Interface
- DATA_WIDTH, 32, width of the data token
- EXPECTED, 0, value every accepted token must equal
- TOKEN_COUNT, 4, tokens accepted per emitted control token; legal range 1..2^CNT_WIDTH-1
- CNT_WIDTH, 16, width of the batch and total counters

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- ins  input  DATA_WIDTH  data token
- ins_valid  input  1  data token present
- ins_ready  output  1  block can accept the data token
- ctrl_valid  output  1  control token (batch complete) present
- ctrl_ready  input  1  downstream accepts the control token
- count  output  CNT_WIDTH  total tokens accepted since reset, saturating
- mismatch  output  1  sticky; set when any accepted token differs from EXPECTED
- last_value  output  DATA_WIDTH  most recently accepted token

## Operation
- Input fire: ins_valid && ins_ready. Output fire: ctrl_valid && ctrl_ready.
- Two-state FSM, registered:
  - ACCEPT: ins_ready=1, ctrl_valid=0. Each input fire increments the batch counter. A fire while batch == TOKEN_COUNT-1 clears the batch counter and moves to EMIT.
  - EMIT: ins_ready=0, ctrl_valid=1. Output fire returns to ACCEPT. No input is accepted in EMIT.
- ins_ready and ctrl_valid are decoded from the state register only; they have no combinational path from ins_valid or ctrl_ready.
- count increments by 1 on each input fire and holds at all-ones, with no wrap.
- last_value loads ins on each input fire.
- mismatch is set on an input fire with ins != EXPECTED, compared at full DATA_WIDTH. It clears only on reset.
- TOKEN_COUNT=1: every input fire moves the FSM to EMIT.
- Reset values:
  - state = ACCEPT, so ins_ready=1 and ctrl_valid=0
  - batch counter = 0, count = 0, mismatch = 0, last_value = 0
- Reset asserted mid-operation, including in EMIT with ctrl_valid high: the pending control token is dropped and all registers return to reset values asynchronously.

## Timing
- Input accept: one token per cycle while in ACCEPT.
- Last-token-to-control latency: the input fire in cycle n raises ctrl_valid in cycle n+1.
- ctrl_valid stays high until ctrl_ready is sampled high. The first input can then fire in the following cycle.
- Best-case throughput: TOKEN_COUNT tokens per TOKEN_COUNT+1 cycles.
- count, last_value and mismatch update in the cycle after the fire.
- ctrl_valid never falls without an output fire, except on reset.

## Configuration
- HANDSHAKE_CONST_SINK_CHECK_EN defined: the EXPECTED comparator and mismatch register are instantiated as described above.
- Not defined: there is no comparator, mismatch is tied to 0, and the EXPECTED parameter is ignored. All handshake, count and last_value behaviour is unchanged.

## Test plan
- Reset then idle. Hold rst low, then release with no stimulus.
  - Required: ins_ready=1, ctrl_valid=0, count=0, mismatch=0, last_value=0.
- Streaming batch. TOKEN_COUNT=4, EXPECTED=5, ins=5 with ins_valid high for 4 consecutive cycles, ctrl_ready=1.
  - Required: ctrl_valid high for exactly 1 cycle, in the cycle after the 4th fire.
  - Required: ins_ready low in that cycle, count=4, mismatch=0.
- Backpressure. Same as streaming batch but ctrl_ready=0 for 3 cycles after ctrl_valid rises.
  - Required: ctrl_valid stays high for 4 cycles, ins_ready stays 0, and no token is accepted.
- Mismatch. Send 2nd token 0x6 with EXPECTED=5, macro defined.
  - Required: mismatch=1 from the next cycle, persisting through further correct tokens; last_value=6.
  - With macro undefined: mismatch stays 0.
- Saturation and TOKEN_COUNT=1. CNT_WIDTH=4, TOKEN_COUNT=1, send 20 tokens with ctrl_ready=1.
  - Required: count reaches 15 and holds.
  - Required: 20 control tokens emitted, alternating ACCEPT/EMIT every cycle.
- Reset in EMIT. Assert rst while ctrl_valid=1.
  - Required: ctrl_valid=0 immediately (asynchronous) and count=0.
  - Required: after release, a new batch needs a full TOKEN_COUNT tokens.
